// File: rtl/clint_mtimer.sv
// CLINT msip/mtimecmp/mtime slave: 1-cycle registered ack and rdata, irq_timer registered.
// No backpressure: every accepted request completes in the next cycle; req held through ack is not a new transfer.
module clint_mtimer #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        irq_sw,
  output logic        irq_timer
);

  localparam logic [15:0] PRE_MAX   = 16'(TICK_DIV - 1);
  localparam logic [13:0] W_MSIP    = 14'h0000;
  localparam logic [13:0] W_CMP_LO  = 14'h1000;
  localparam logic [13:0] W_CMP_HI  = 14'h1001;
  localparam logic [13:0] W_TIME_LO = 14'h2FFE;
  localparam logic [13:0] W_TIME_HI = 14'h2FFF;

  logic [15:0] pre;
  logic        tick;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;
  logic        accept;
  logic        wr;
  logic [13:0] widx;
  logic [31:0] rd_mux;
  logic        wr_msip, wr_cmp_lo, wr_cmp_hi, wr_time_lo, wr_time_hi;
  logic        unused_addr;

  assign widx        = addr[15:2];
  assign unused_addr = ^addr[1:0];
  assign accept      = req & ~ack;
  assign wr          = accept & we;
  assign tick        = (pre == PRE_MAX);

  assign wr_msip    = wr && (widx == W_MSIP);
  assign wr_cmp_lo  = wr && (widx == W_CMP_LO);
  assign wr_cmp_hi  = wr && (widx == W_CMP_HI);
  assign wr_time_lo = wr && (widx == W_TIME_LO);
  assign wr_time_hi = wr && (widx == W_TIME_HI);

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] wd,
                                        input logic [3:0] mask);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = mask[i] ? wd[8*i +: 8] : cur[8*i +: 8];
    end
    return r;
  endfunction

  always_comb begin
    rd_mux = 32'h0;
    case (widx)
      W_MSIP:    rd_mux = {31'h0, msip};
      W_CMP_LO:  rd_mux = mtimecmp[31:0];
      W_CMP_HI:  rd_mux = mtimecmp[63:32];
      W_TIME_LO: rd_mux = mtime[31:0];
      W_TIME_HI: rd_mux = mtime[63:32];
      default:   rd_mux = 32'h0;
    endcase
  end

  // Prescaler free-runs; bus traffic never disturbs its phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= 16'h0;
    end else if (tick) begin
      pre <= 16'h0;
    end else begin
      pre <= pre + 16'd1;
    end
  end

  // A write to either half suppresses the tick for the whole 64-bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime <= 64'h0;
    end else if (wr_time_lo || wr_time_hi) begin
      if (wr_time_lo) mtime[31:0]  <= merge(mtime[31:0], wdata, be);
      if (wr_time_hi) mtime[63:32] <= merge(mtime[63:32], wdata, be);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip     <= 1'b0;
    end else begin
      if (wr_cmp_lo) mtimecmp[31:0]  <= merge(mtimecmp[31:0], wdata, be);
      if (wr_cmp_hi) mtimecmp[63:32] <= merge(mtimecmp[63:32], wdata, be);
      if (wr_msip && be[0]) msip <= wdata[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack       <= 1'b0;
      rdata     <= 32'h0;
      irq_timer <= 1'b0;
    end else begin
      ack       <= accept;
      rdata     <= (accept && !we) ? rd_mux : 32'h0;
      irq_timer <= (mtime >= mtimecmp);
    end
  end

  assign irq_sw = msip;

endmodule

// File: doc/clint_mtimer.md
# clint_mtimer

Core-local interruptor timer/software-interrupt block for riscv32 core-0. It sits on the D-bus as a memory-mapped slave and directly drives the core's `irq_timer` and `irq_sw` inputs. It implements the RISC-V `msip`, `mtimecmp` and `mtime` registers, and replaces the current tie-off CLINT. A free-running 64-bit `mtime` advances on a prescaled tick; a timer interrupt is raised while `mtime >= mtimecmp`.

## Interface
- `TICK_DIV`, default 1: `clk` cycles per `mtime` increment. Legal range is 1..65535.
- `clk`  in  1  system clock (divided clock domain); single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  1  bus request; held high until `ack`.
- `we`  in  1  1 = write, 0 = read; stable while `req` is high.
- `addr`  in  16  byte offset within the block; bits [1:0] are ignored.
- `wdata`  in  32  write data.
- `be`  in  4  byte enables for writes; ignored on reads.
- `rdata`  out  32  read data; valid only while `ack` is high, 0 otherwise.
- `ack`  out  1  one-cycle transfer completion.
- `irq_sw`  out  1  machine software interrupt (= `msip[0]`).
- `irq_timer`  out  1  machine timer interrupt.

## Operation
- Register map:
  - 0x0000: `msip`. Bit 0 is R/W; bits 31:1 read 0.
  - 0x4000 / 0x4004: `mtimecmp` low / high.
  - 0xBFF8 / 0xBFFC: `mtime` low / high.
- Unmapped offsets: writes are ignored, reads return 0, and the transfer is still acked.
- Writes honor `be` per byte. A partial write merges with the current contents.
- A write to one half of `mtime` or `mtimecmp` leaves the other half untouched. There is no carry or borrow between halves on a write.
- Prescaler:
  - `pre` counts 0..`TICK_DIV`-1. A tick occurs in the cycle `pre == TICK_DIV-1`, and `pre` then wraps to 0.
  - With `TICK_DIV`=1, a tick occurs every cycle.
  - `pre` is never reset by bus writes.
- On a tick, `mtime <= mtime + 1` (64-bit, unsigned). At 2^64-1 it wraps to 0.
- Simultaneous tick and `mtime` write (either half): the write wins and the tick is lost, for both halves.
- `irq_timer` is registered: it is set to `(mtime >= mtimecmp)` (64-bit unsigned) evaluated on the current register values.
- `irq_sw` is driven directly from the `msip[0]` flop.
- Reset values:
  - `mtime` = 0, `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF, `msip` = 0, `pre` = 0.
  - `ack` = 0, `rdata` = 0, `irq_timer` = 0, `irq_sw` = 0.
- Reset mid-transfer: the transfer is dropped with no `ack`. The master must reissue it after reset.

## Timing
- Accept condition: a transfer is accepted at the rising edge where `req`=1 and `ack`=0.
- Writes take effect at that same edge.
- `ack` and read `rdata` are registered and high for exactly the following cycle, giving a fixed latency of 1.
- Read data reflects register contents before any same-edge tick.
- `req` still high during the `ack` cycle is not a new transfer. Peak throughput is one transfer per 2 cycles.
- `irq_timer` lags a change of `mtime` or `mtimecmp` by 1 cycle.
- Write to `mtimecmp` at edge N: `irq_timer` reflects the new value after edge N+1.
- `irq_sw` follows a `msip` write at the same edge as `ack` rises.
- Software reading 64-bit `mtime` must use hi-lo-hi; the block provides no atomic snapshot.

## Test plan
- **Reset:** assert `rst_n`=0 asynchronously mid-cycle. Required: all outputs 0 immediately; after release, read 0xBFF8 = 0, 0x4000 = 0xFFFF_FFFF, 0x4004 = 0xFFFF_FFFF; each `ack` occurs exactly 1 cycle after accept.
- **Counting and wrap:** with `TICK_DIV`=4, 40 cycles after reset `mtime` = 10. Write `mtime` hi = 0xFFFF_FFFF and lo = 0xFFFF_FFFF, then wait 4 cycles: `mtime` = 0 and hi = 0.
- **Timer compare:** write `mtimecmp` hi = 0, then lo = 100, with `TICK_DIV`=1. Required: `irq_timer` rises exactly 1 cycle after `mtime` reaches 100. Write lo = 0xFFFF_FFFF: `irq_timer` falls 1 cycle after that write's accept edge + 1.
- **Software interrupt and byte enables:** write 0x0000 `wdata`=0xFFFF_FFFF, `be`=4'b0001. Required: `irq_sw`=1 and read-back = 0x0000_0001. Write `wdata`=0 with `be`=4'b1110: `irq_sw` stays 1. Write `be`=4'b0001 with 0: `irq_sw`=0.
- **Collision and unmapped:** issue an `mtime` lo write of 0x55 in a tick cycle. Required: the next read = 0x55, or 0x56 if a later tick occurred before the read. Write to 0x1000, then read it: data 0, `ack` after 1 cycle, no register changes.
- **Held `req`:** hold `req` high for 6 cycles on a read. Required: exactly 3 `ack` pulses, on alternate cycles.
